// File: rtl/reg_file_pkg.sv
// Shared register-file constants and types, imported by reg_file, reg_read_port and reg_file_if.
package riscv_pkg;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned REG_ADDR_W = $clog2(NUM_REGS);

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/reg_file_if.sv
// Read/write bus of the register file; master is the datapath, slave is reg_file.
interface reg_file_if
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN   = riscv_pkg::XLEN,
  parameter int unsigned ADDR_W = riscv_pkg::REG_ADDR_W
);
  logic [ADDR_W-1:0] rs1_addr;
  logic [ADDR_W-1:0] rs2_addr;
  logic [XLEN-1:0]   read_data1;
  logic [XLEN-1:0]   read_data2;
  logic              rs1_valid;
  logic              rs2_valid;
  logic              reg_write;
  logic [ADDR_W-1:0] rd_addr;
  logic [XLEN-1:0]   write_data;

  modport master (
    output rs1_addr, rs2_addr, reg_write, rd_addr, write_data,
    input  read_data1, read_data2, rs1_valid, rs2_valid
  );

  modport slave (
    input  rs1_addr, rs2_addr, reg_write, rd_addr, write_data,
    output read_data1, read_data2, rs1_valid, rs2_valid
  );
endinterface

// File: rtl/reg_read_port.sv
// One combinational read port: select, x0 force and written-mask lookup.
// Write-to-read forwarding is compiled in only when REG_FILE_BYPASS_EN is defined.
module reg_read_port
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN     = riscv_pkg::XLEN,
  parameter int unsigned NUM_REGS = riscv_pkg::NUM_REGS
) (
  input  logic [REG_ADDR_W-1:0] addr_i,
  input  logic [XLEN-1:0]       regs_i [NUM_REGS],
  input  logic [NUM_REGS-1:0]   written_i,
`ifdef REG_FILE_BYPASS_EN
  input  logic                  reset_i,
  input  logic                  reg_write_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  input  logic [XLEN-1:0]       write_data_i,
`endif
  output logic [XLEN-1:0]       data_o,
  output logic                  valid_o
);

  always_comb begin
    data_o  = regs_i[addr_i];
    valid_o = written_i[addr_i];
    if (addr_i == REG_ZERO) begin
      data_o  = '0;
      valid_o = 1'b1;
    end
`ifdef REG_FILE_BYPASS_EN
    // Reset suppresses forwarding so the port reads the cleared state.
    if (!reset_i && reg_write_i && (rd_addr_i != REG_ZERO) && (rd_addr_i == addr_i)) begin
      data_o  = write_data_i;
      valid_o = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/reg_file.sv
// 2-read/1-write register file with x0 hardwired to zero and a per-register written mask.
// Optional same-cycle write forwarding via REG_FILE_BYPASS_EN.
module reg_file
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN     = riscv_pkg::XLEN,
  parameter int unsigned NUM_REGS = riscv_pkg::NUM_REGS
) (
  input  logic      clk,
  input  logic      reset,
  reg_file_if.slave rf
);

  logic [XLEN-1:0]     regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] written_q;
  logic [NUM_REGS-1:0] written_d;
  logic                wr_en;

  assign wr_en = rf.reg_write && (rf.rd_addr != REG_ZERO);

  always_comb begin
    written_d = written_q;
    if (wr_en) begin
      written_d[rf.rd_addr] = 1'b1;
    end
    written_d[0] = 1'b1;
  end

  // regs_q[0] is never written, so it stays zero from reset onward.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q    <= '{default: '0};
      written_q <= {{(NUM_REGS-1){1'b0}}, 1'b1};
    end else begin
      if (wr_en) begin
        regs_q[rf.rd_addr] <= rf.write_data;
      end
      written_q <= written_d;
    end
  end

  reg_read_port #(.XLEN(XLEN), .NUM_REGS(NUM_REGS)) u_rd1 (
    .addr_i       (rf.rs1_addr),
    .regs_i       (regs_q),
    .written_i    (written_q),
`ifdef REG_FILE_BYPASS_EN
    .reset_i      (reset),
    .reg_write_i  (rf.reg_write),
    .rd_addr_i    (rf.rd_addr),
    .write_data_i (rf.write_data),
`endif
    .data_o       (rf.read_data1),
    .valid_o      (rf.rs1_valid)
  );

  reg_read_port #(.XLEN(XLEN), .NUM_REGS(NUM_REGS)) u_rd2 (
    .addr_i       (rf.rs2_addr),
    .regs_i       (regs_q),
    .written_i    (written_q),
`ifdef REG_FILE_BYPASS_EN
    .reset_i      (reset),
    .reg_write_i  (rf.reg_write),
    .rd_addr_i    (rf.rd_addr),
    .write_data_i (rf.write_data),
`endif
    .data_o       (rf.read_data2),
    .valid_o      (rf.rs2_valid)
  );

endmodule
